// File: rtl/input_conditioner.sv
// input_conditioner: front end for the 8-bit add/shift multiplier.
// Synchronises and debounces the two active-low keys, then emits one-cycle
// press pulses gated by Busy. Also provides a 2-flop-synchronised copy of
// the operand switches.
//
// Ports:
//   Clk           - system clock, all state on the rising edge
//   Reset         - asynchronous active-high reset
//   ClearALoadB_n - raw active-low key, asynchronous
//   Execute_n     - raw active-low key, asynchronous
//   Switches_raw  - raw slide switches, asynchronous
//   Busy          - control FSM is mid-multiply
//   ClearALoadB_P - one-cycle pulse per accepted ClearALoadB press
//   Execute_P     - one-cycle pulse per accepted Execute press
//   Execute_Lvl   - debounced Execute level, not gated by Busy
//   Switches_S    - synchronised switches
//
// Optional macro SWITCH_LATCH_EN: when defined, Switches_S only loads from
// the synchronised switches in the cycle a key pulse is generated, so the
// operand stays frozen for the whole multiply.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClearALoadB_n,
    input  logic       Execute_n,
    input  logic [7:0] Switches_raw,
    input  logic       Busy,
    output logic       ClearALoadB_P,
    output logic       Execute_P,
    output logic       Execute_Lvl,
    output logic [7:0] Switches_S
);

    // Key channels are packed as index 0 = ClearALoadB, index 1 = Execute.
    localparam int NKEY = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NKEY-1:0]  key_raw;

    logic [NKEY-1:0]  s1_q, s1_d;
    logic [NKEY-1:0]  s2_q, s2_d;
    logic [NKEY-1:0]  stable_q, stable_d;
    logic [NKEY-1:0]  pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q [NKEY];
    logic [CNT_W-1:0] cnt_d [NKEY];

    logic [7:0]       sw_s1_q, sw_s1_d;
    logic [7:0]       sw_s2_q, sw_s2_d;

    // Invert to active-high so the reset value 0 means "released".
    assign key_raw = {~Execute_n, ~ClearALoadB_n};

    always_comb begin
        s1_d    = key_raw;
        s2_d    = s1_q;
        sw_s1_d = Switches_raw;
        sw_s2_d = sw_s1_q;
        for (int k = 0; k < NKEY; k++) begin
            stable_d[k] = stable_q[k];
            cnt_d[k]    = '0;
            // Any return to the stable level leaves cnt at 0, so a bounce
            // restarts the count; reaching CNT_LAST accepts the new level.
            if (s2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    stable_d[k] = s2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
        // Rising edge of the accepted level, dropped (not queued) if busy.
        pulse_d = stable_d & ~stable_q & {NKEY{~Busy}};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            for (int k = 0; k < NKEY; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            for (int k = 0; k < NKEY; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign ClearALoadB_P = pulse_q[0];
    assign Execute_P     = pulse_q[1];
    assign Execute_Lvl   = stable_q[1];

`ifdef SWITCH_LATCH_EN
    logic [7:0] sw_lat_q, sw_lat_d;

    // Load in the same edge that raises either pulse.
    always_comb begin
        sw_lat_d = sw_lat_q;
        if (|pulse_d) begin
            sw_lat_d = sw_s2_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sw_lat_q <= '0;
        end else begin
            sw_lat_q <= sw_lat_d;
        end
    end

    assign Switches_S = sw_lat_q;
`else
    assign Switches_S = sw_s2_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Table-driven vectors plus hand-written multi-cycle sequences.
module tb_input_conditioner;

    logic       clk;
    logic       rst;
    logic       clr_n;
    logic       exe_n;
    logic [7:0] sw_raw;
    logic       busy;
    logic       clr_p;
    logic       exe_p;
    logic       exe_lvl;
    logic [7:0] sw_s;

    int errors;
    int checks;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clk          (clk),
        .Reset        (rst),
        .ClearALoadB_n(clr_n),
        .Execute_n    (exe_n),
        .Switches_raw (sw_raw),
        .Busy         (busy),
        .ClearALoadB_P(clr_p),
        .Execute_P    (exe_p),
        .Execute_Lvl  (exe_lvl),
        .Switches_S   (sw_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       exe_n;
        logic       clr_n;
        logic       busy;
        logic [7:0] sw;
        logic       e_p;
        logic       c_p;
        logic       lvl;
        logic [7:0] sw_exp;
        logic [7:0] sw_lat_exp;
    } vec_t;

    vec_t tab [30];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int npulse;
        logic [7:0] swe;
        errors = 0;
        checks = 0;

        // Press Execute with switches moving to A5, then 3C, then release.
        tab[0]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tab[1]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00};
        tab[2]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00};
        tab[3]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00};
        tab[4]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00};
        tab[5]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 8'hA5};
        tab[6]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5};
        tab[7]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5};
        tab[8]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5};
        tab[9]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5};
        tab[10] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5};
        tab[11] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5};
        tab[12] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5};
        tab[13] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5};
        tab[14] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5};
        tab[15] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5};
        // Press ClearALoadB: latched copy picks up 3C only on its pulse.
        tab[16] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5};
        tab[17] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5};
        tab[18] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5};
        tab[19] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5};
        tab[20] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5};
        tab[21] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C};
        tab[22] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
        tab[23] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
        tab[24] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
        tab[25] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
        tab[26] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
        tab[27] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
        tab[28] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
        tab[29] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};

        rst    = 1'b1;
        clr_n  = 1'b1;
        exe_n  = 1'b1;
        sw_raw = 8'h00;
        busy   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_clr_p", clr_p, 1'b0);
        chk1("reset_exe_p", exe_p, 1'b0);
        chk1("reset_lvl", exe_lvl, 1'b0);
        chk8("reset_sw", sw_s, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            exe_n  = tab[i].exe_n;
            clr_n  = tab[i].clr_n;
            busy   = tab[i].busy;
            sw_raw = tab[i].sw;
            step();
`ifdef SWITCH_LATCH_EN
            swe = tab[i].sw_lat_exp;
`else
            swe = tab[i].sw_exp;
`endif
            chk1($sformatf("tab%0d_exe_p", i), exe_p, tab[i].e_p);
            chk1($sformatf("tab%0d_clr_p", i), clr_p, tab[i].c_p);
            chk1($sformatf("tab%0d_lvl", i), exe_lvl, tab[i].lvl);
            chk8($sformatf("tab%0d_sw", i), sw_s, swe);
        end

        // Short glitches (3 low cycles) never reach the 4-cycle window.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                exe_n = (c < 3) ? 1'b0 : 1'b1;
                step();
                chk1("glitch_exe_p", exe_p, 1'b0);
                chk1("glitch_lvl", exe_lvl, 1'b0);
            end
        end
        exe_n  = 1'b0;
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (exe_p) npulse++;
        end
        chk_int("glitch_then_press_pulses", npulse, 1);
        chk1("glitch_then_press_lvl", exe_lvl, 1'b1);
        exe_n = 1'b1;
        repeat (8) step();
        chk1("glitch_release_lvl", exe_lvl, 1'b0);

        // Press accepted while busy is dropped, and not replayed later.
        busy  = 1'b1;
        clr_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk1("busy_clr_p", clr_p, 1'b0);
        end
        busy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk1("busy_drop_clr_p", clr_p, 1'b0);
        end
        clr_n = 1'b1;
        repeat (8) step();
        clr_n  = 1'b0;
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (clr_p) npulse++;
        end
        chk_int("busy_repress_pulses", npulse, 1);
        clr_n = 1'b1;
        repeat (8) step();

        // Both keys on the same edge.
        clr_n = 1'b0;
        exe_n = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk1($sformatf("both_clr_p_e%0d", c), clr_p, c == 6);
            chk1($sformatf("both_exe_p_e%0d", c), exe_p, c == 6);
        end
        clr_n = 1'b1;
        exe_n = 1'b1;
        repeat (8) step();

        // Reset mid-debounce with the key held through reset release.
        sw_raw = 8'h5A;
        exe_n  = 1'b0;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        chk1("rstmid_exe_p", exe_p, 1'b0);
        chk1("rstmid_clr_p", clr_p, 1'b0);
        chk1("rstmid_lvl", exe_lvl, 1'b0);
        chk8("rstmid_sw", sw_s, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk1($sformatf("rstrel_exe_p_e%0d", c), exe_p, c == 6);
            chk1($sformatf("rstrel_lvl_e%0d", c), exe_lvl, c >= 6);
        end
        exe_n = 1'b1;
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
